// File: rtl/sm4_pkg.sv
// Shared SM4 constants and word-level helpers for the iterative round controller.
// Holds the state encoding, FK words, CK generator and the two linear transforms.
package sm4_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StKeyExp = 2'd1,
        StReady  = 2'd2,
        StCrypt  = 2'd3
    } state_e;

    localparam int unsigned NumRounds = 32;

    localparam logic [31:0] FK0 = 32'hA3B1BAC6;
    localparam logic [31:0] FK1 = 32'h56AA3350;
    localparam logic [31:0] FK2 = 32'h677D9197;
    localparam logic [31:0] FK3 = 32'hB27022DC;

    function automatic logic [31:0] rotl(input logic [31:0] x, input int unsigned n);
        return (x << n) | (x >> (32 - n));
    endfunction

    // Byte j of CK word i is (4i+j)*7 mod 256, byte 0 in the top bits.
    function automatic logic [31:0] ck_word(input logic [4:0] i);
        logic [31:0] w;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            w[31-8*j -: 8] = 8'(((4 * int'(i) + j) * 7) % 256);
        end
        return w;
    endfunction

    function automatic logic [31:0] l_data(input logic [31:0] b);
        return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
    endfunction

    function automatic logic [31:0] l_key(input logic [31:0] b);
        return b ^ rotl(b, 13) ^ rotl(b, 23);
    endfunction

endpackage

// File: rtl/sm4_tau.sv
// SM4 non-linear tau transform: four parallel byte S-box lookups on a 32-bit word.
module sm4_tau (
    input  logic [31:0] i_word,
    output logic [31:0] o_word
);

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    for (genvar b = 0; b < 4; b++) begin : g_sbox
        logic [7:0] w_in;
        assign w_in = i_word[8*b +: 8];
        assign o_word[8*b +: 8] = SBOX[2047 - 8*int'(w_in) -: 8];
    end

endmodule

// File: rtl/sm4_round_ctrl.sv
// Iterative SM4 controller: 32-cycle key expansion into a round-key file, then
// 32-cycle encrypt/decrypt passes sharing one tau unit and one 4-word window.
module sm4_round_ctrl
    import sm4_pkg::*;
(
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_key_valid,
    input  logic [127:0]   i_key,
    output logic           o_key_ready,
    output logic           o_keyed,
    input  logic           i_in_valid,
    input  logic           i_decrypt,
    input  logic [127:0]   i_data_in,
    output logic           o_in_ready,
    output logic           o_out_valid,
    output logic [127:0]   o_data_out,
    output logic           o_busy
);

    state_e         r_state;
    logic [4:0]     r_cnt;
    logic [31:0]    r_win [4];
    logic [31:0]    r_rk [NumRounds];
    logic           r_decrypt;
    logic           r_key_ready;
    logic           r_keyed;
    logic           r_in_ready;
    logic           r_out_valid;
    logic           r_busy;
    logic [127:0]   r_data_out;

    logic           w_key_phase;
    logic [4:0]     w_rk_idx;
    logic [31:0]    w_mix;
    logic [31:0]    w_tau_in;
    logic [31:0]    w_tau_out;
    logic [31:0]    w_new;

    // The window holds K0..K3 during expansion and X0..X3 during a pass.
    always_comb begin
        w_key_phase = (r_state == StKeyExp);
        w_rk_idx    = r_decrypt ? (5'd31 - r_cnt) : r_cnt;
        w_mix       = r_win[1] ^ r_win[2] ^ r_win[3];
        w_tau_in    = w_key_phase ? (w_mix ^ ck_word(r_cnt)) : (w_mix ^ r_rk[w_rk_idx]);
        w_new       = r_win[0] ^ (w_key_phase ? l_key(w_tau_out) : l_data(w_tau_out));
    end

    sm4_tau u_tau (
        .i_word (w_tau_in),
        .o_word (w_tau_out)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_decrypt   <= 1'b0;
            r_key_ready <= 1'b1;
            r_keyed     <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_data_out  <= '0;
            for (int i = 0; i < 4; i++) begin
                r_win[i] <= '0;
            end
            for (int i = 0; i < int'(NumRounds); i++) begin
                r_rk[i] <= '0;
            end
        end else begin
            r_out_valid <= 1'b0;
            unique case (r_state)
                StIdle, StReady: begin
                    // A key request outranks a pending block.
                    if (i_key_valid) begin
                        r_win[0]    <= i_key[127:96] ^ FK0;
                        r_win[1]    <= i_key[95:64]  ^ FK1;
                        r_win[2]    <= i_key[63:32]  ^ FK2;
                        r_win[3]    <= i_key[31:0]   ^ FK3;
                        r_cnt       <= '0;
                        r_state     <= StKeyExp;
                        r_keyed     <= 1'b0;
                        r_key_ready <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end else if ((r_state == StReady) && i_in_valid) begin
                        r_win[0]    <= i_data_in[127:96];
                        r_win[1]    <= i_data_in[95:64];
                        r_win[2]    <= i_data_in[63:32];
                        r_win[3]    <= i_data_in[31:0];
                        r_decrypt   <= i_decrypt;
                        r_cnt       <= '0;
                        r_state     <= StCrypt;
                        r_key_ready <= 1'b0;
                        r_in_ready  <= 1'b0;
                        r_busy      <= 1'b1;
                    end
                end
                StKeyExp: begin
                    r_rk[r_cnt] <= w_new;
                    r_win[0]    <= r_win[1];
                    r_win[1]    <= r_win[2];
                    r_win[2]    <= r_win[3];
                    r_win[3]    <= w_new;
                    r_cnt       <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        r_state     <= StReady;
                        r_keyed     <= 1'b1;
                        r_key_ready <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                StCrypt: begin
                    r_win[0] <= r_win[1];
                    r_win[1] <= r_win[2];
                    r_win[2] <= r_win[3];
                    r_win[3] <= w_new;
                    r_cnt    <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        // Result is X35,X34,X33,X32: the final window word-reversed.
                        r_data_out  <= {w_new, r_win[3], r_win[2], r_win[1]};
                        r_out_valid <= 1'b1;
                        r_state     <= StReady;
                        r_key_ready <= 1'b1;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_key_ready = r_key_ready;
    assign o_keyed     = r_keyed;
    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_data_out  = r_data_out;
    assign o_busy      = r_busy;

endmodule

// File: tb/tb_sm4_round_ctrl.sv
// Directed bench for sm4_round_ctrl: table of key/block vectors against a
// behavioural SM4 model, plus hand-written back-to-back, priority and reset sequences.
module tb_sm4_round_ctrl;

    localparam logic [127:0] KEY_A = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] PT_A  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] CT_A  = 128'h681EDF34D206965E86B3E94F536E4246;
    localparam logic [127:0] KEY_B = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] PT_B  = 128'h00112233445566778899AABBCCDDEEFF;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         key_valid = 1'b0;
    logic [127:0] key = '0;
    logic         key_ready;
    logic         keyed;
    logic         in_valid = 1'b0;
    logic         decrypt = 1'b0;
    logic [127:0] data_in = '0;
    logic         in_ready;
    logic         out_valid;
    logic [127:0] data_out;
    logic         busy;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm4_round_ctrl dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_key_valid (key_valid),
        .i_key       (key),
        .o_key_ready (key_ready),
        .o_keyed     (keyed),
        .i_in_valid  (in_valid),
        .i_decrypt   (decrypt),
        .i_data_in   (data_in),
        .o_in_ready  (in_ready),
        .o_out_valid (out_valid),
        .o_data_out  (data_out),
        .o_busy      (busy)
    );

    // ---------------- reference model ----------------
    logic [2047:0] tb_sbox = {
        128'hd690e9fecce13db716b614c228fb2c05, 128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62, 128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8, 128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887, 128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1, 128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f, 128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8, 128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684, 128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    function automatic logic [31:0] rol(input logic [31:0] x, input int n);
        return (x << n) | (x >> (32 - n));
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        logic [31:0] r;
        for (int b = 0; b < 4; b++) begin
            r[8*b +: 8] = tb_sbox[2047 - 8*int'(w[8*b +: 8]) -: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] ref_sm4(input logic [127:0] k_in, input logic [127:0] blk,
                                             input logic dec);
        logic [31:0] k [36];
        logic [31:0] rk [32];
        logic [31:0] x [36];
        logic [31:0] t;
        logic [31:0] ck;
        k[0] = k_in[127:96] ^ 32'hA3B1BAC6;
        k[1] = k_in[95:64]  ^ 32'h56AA3350;
        k[2] = k_in[63:32]  ^ 32'h677D9197;
        k[3] = k_in[31:0]   ^ 32'hB27022DC;
        for (int i = 0; i < 32; i++) begin
            for (int j = 0; j < 4; j++) ck[31-8*j -: 8] = 8'(((4 * i + j) * 7) & 255);
            t = sub_word(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
            k[i+4] = k[i] ^ t ^ rol(t, 13) ^ rol(t, 23);
            rk[i] = k[i+4];
        end
        x[0] = blk[127:96]; x[1] = blk[95:64]; x[2] = blk[63:32]; x[3] = blk[31:0];
        for (int i = 0; i < 32; i++) begin
            t = sub_word(x[i+1] ^ x[i+2] ^ x[i+3] ^ (dec ? rk[31-i] : rk[i]));
            x[i+4] = x[i] ^ t ^ rol(t, 2) ^ rol(t, 10) ^ rol(t, 18) ^ rol(t, 24);
        end
        return {x[35], x[34], x[33], x[32]};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_key(input logic [127:0] k);
        int n;
        check("key_ready before load", 128'(key_ready), 128'd1);
        key_valid = 1'b1;
        key = k;
        tick();
        key_valid = 1'b0;
        check("busy in KEY_EXP", 128'(busy), 128'd1);
        n = 0;
        while (!keyed && n < 40) begin
            tick();
            n++;
        end
        check("key expansion latency", 128'(n), 128'd32);
        check("in_ready after keyed", 128'(in_ready), 128'd1);
        if (k == KEY_A) begin
            check("rk0 standard key", 128'(dut.r_rk[0]), 128'h F12186F9);
            check("rk31 standard key", 128'(dut.r_rk[31]), 128'h9124A012);
        end
    endtask

    task automatic run_block(input string name, input logic [127:0] din, input logic dec,
                             input logic [127:0] exp);
        int n;
        logic bad_ready;
        check({name, " in_ready"}, 128'(in_ready), 128'd1);
        in_valid = 1'b1;
        data_in = din;
        decrypt = dec;
        tick();
        in_valid = 1'b0;
        n = 0;
        bad_ready = 1'b0;
        while (!out_valid && n < 40) begin
            if (in_ready) bad_ready = 1'b1;
            tick();
            n++;
        end
        check({name, " latency"}, 128'(n), 128'd32);
        check({name, " in_ready low in CRYPT"}, 128'(bad_ready), 128'd0);
        check({name, " data_out"}, data_out, exp);
        tick();
        check({name, " out_valid one cycle"}, 128'(out_valid), 128'd0);
        check({name, " data_out held"}, data_out, exp);
    endtask

    typedef struct {
        string        name;
        logic [127:0] k;
        logic [127:0] din;
        logic         dec;
        logic [127:0] exp;
    } vec_t;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t vecs [6];
        logic [127:0] cur_key;
        logic         have_key;
        logic         flag;
        int           n;
        int           acc;
        int           prev_acc;

        vecs[0] = '{"std encrypt", KEY_A, PT_A, 1'b0, CT_A};
        vecs[1] = '{"std decrypt", KEY_A, CT_A, 1'b1, PT_A};
        vecs[2] = '{"keyB encrypt", KEY_B, PT_B, 1'b0, ref_sm4(KEY_B, PT_B, 1'b0)};
        vecs[3] = '{"keyB decrypt", KEY_B, ref_sm4(KEY_B, PT_B, 1'b0), 1'b1, PT_B};
        vecs[4] = '{"keyA reload encrypt", KEY_A, PT_B, 1'b0, ref_sm4(KEY_A, PT_B, 1'b0)};
        vecs[5] = '{"keyA encrypt ct", KEY_A, CT_A, 1'b0, ref_sm4(KEY_A, CT_A, 1'b0)};

        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("reset key_ready", 128'(key_ready), 128'd1);
        check("reset keyed", 128'(keyed), 128'd0);
        check("reset in_ready", 128'(in_ready), 128'd0);
        check("reset out_valid", 128'(out_valid), 128'd0);
        check("reset busy", 128'(busy), 128'd0);
        check("reset data_out", data_out, 128'd0);

        // Block requests with no key loaded must never be taken.
        in_valid = 1'b1;
        data_in = PT_A;
        flag = 1'b0;
        repeat (10) begin
            tick();
            if (in_ready || busy || out_valid) flag = 1'b1;
        end
        in_valid = 1'b0;
        check("in_valid before key ignored", 128'(flag), 128'd0);

        have_key = 1'b0;
        cur_key = '0;
        for (int i = 0; i < 6; i++) begin
            if (!have_key || vecs[i].k != cur_key) begin
                load_key(vecs[i].k);
                cur_key = vecs[i].k;
                have_key = 1'b1;
            end
            run_block(vecs[i].name, vecs[i].din, vecs[i].dec, vecs[i].exp);
        end

        // Back-to-back: in_valid held high, alternating encrypt/decrypt under KEY_A.
        in_valid = 1'b1;
        data_in = PT_A;
        decrypt = 1'b0;
        prev_acc = 0;
        for (int i = 0; i < 4; i++) begin
            n = 0;
            while (!in_ready && n < 40) begin
                tick();
                n++;
            end
            acc = cyc;
            if (i > 0) check("b2b accept spacing", 128'(acc - prev_acc), 128'd33);
            prev_acc = acc;
            tick();
            data_in = (i % 2 == 0) ? CT_A : PT_A;
            decrypt = (i % 2 == 0);
            flag = 1'b0;
            n = 0;
            while (!out_valid && n < 40) begin
                if (in_ready) flag = 1'b1;
                tick();
                n++;
            end
            check("b2b in_ready low in CRYPT", 128'(flag), 128'd0);
            check("b2b data_out", data_out, (i % 2 == 0) ? CT_A : PT_A);
        end
        in_valid = 1'b0;
        decrypt = 1'b0;
        tick();

        // Key and block requested together in READY: key wins.
        key_valid = 1'b1;
        key = KEY_B;
        in_valid = 1'b1;
        data_in = PT_B;
        tick();
        key_valid = 1'b0;
        in_valid = 1'b0;
        check("priority busy", 128'(busy), 128'd1);
        check("priority keyed dropped", 128'(keyed), 128'd0);
        flag = 1'b0;
        n = 0;
        while (!keyed && n < 40) begin
            if (out_valid || in_ready) flag = 1'b1;
            tick();
            n++;
        end
        check("priority key expansion latency", 128'(n), 128'd32);
        check("priority no block taken", 128'(flag), 128'd0);
        run_block("keyB after priority", PT_B, 1'b0, ref_sm4(KEY_B, PT_B, 1'b0));

        // Key request during CRYPT is ignored; result still uses KEY_B.
        in_valid = 1'b1;
        data_in = PT_A;
        decrypt = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        key_valid = 1'b1;
        key = KEY_A;
        check("key_ready low in CRYPT", 128'(key_ready), 128'd0);
        repeat (3) tick();
        key_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        check("key during CRYPT result", data_out, ref_sm4(KEY_B, PT_A, 1'b0));
        check("key during CRYPT keyed", 128'(keyed), 128'd1);
        tick();

        // Reset at round 15 of CRYPT.
        in_valid = 1'b1;
        data_in = PT_B;
        tick();
        in_valid = 1'b0;
        repeat (15) tick();
        rst = 1'b1;
        #1;
        check("midrst key_ready", 128'(key_ready), 128'd1);
        check("midrst keyed", 128'(keyed), 128'd0);
        check("midrst in_ready", 128'(in_ready), 128'd0);
        check("midrst busy", 128'(busy), 128'd0);
        check("midrst out_valid", 128'(out_valid), 128'd0);
        check("midrst data_out", data_out, 128'd0);
        tick();
        tick();
        rst = 1'b0;
        flag = 1'b0;
        repeat (40) begin
            tick();
            if (out_valid || keyed) flag = 1'b1;
        end
        check("midrst no out_valid", 128'(flag), 128'd0);
        load_key(KEY_A);
        run_block("after reset encrypt", PT_A, 1'b0, CT_A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
